ddrdll_code_rx: RTL and testbench

- Consumer end of the DDRDLL delay-code interface.
- Samples the DLL's CODE/LOCK outputs, filters and offsets the code, and hands it to the DQS delay-line update port with a req/ack handshake.
- Drives FREEZE back to the DLL while a transfer is in flight.
- Sits between a DDRDLL_CORE instance and the DQSBUF/delay-cell control logic of one DDR bank.

---
 rtl/ddrdll_pkg.sv | 26 ++
 rtl/ddrdll_code_sync.sv | 54 +++++
 rtl/ddrdll_code_rx.sv | 163 ++++++++++++++++
 tb/tb_ddrdll_code_rx.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddrdll_pkg.sv
// Shared types, state encodings and arithmetic helpers for the DDRDLL code receiver.
package ddrdll_pkg;

  localparam int CODE_W   = 9;
  localparam int OFFSET_W = 6;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [2:0]        state_t;

  localparam state_t S_WAIT_LOCK = 3'd0;
  localparam state_t S_TRACK     = 3'd1;
  localparam state_t S_FREEZE    = 3'd2;
  localparam state_t S_REQ       = 3'd3;
  localparam state_t S_DONE      = 3'd4;
  localparam state_t S_RELEASE   = 3'd5;

  // Two guard bits hold both the sign and the carry, so clamping is a bit test.
  function automatic code_t sat_add(input code_t code, input logic [OFFSET_W-1:0] offset);
    logic [CODE_W+1:0] sum;
    sum = {2'b00, code} + {{(CODE_W+2-OFFSET_W){offset[OFFSET_W-1]}}, offset};
    if (sum[CODE_W+1])   return '0;
    else if (sum[CODE_W]) return '1;
    else                  return sum[CODE_W-1:0];
  endfunction

endpackage

// File: rtl/ddrdll_code_sync.sv
// Brings the DLL lock and code into the clk_i domain and flags when the
// synchronised code has been constant for STABLE_CYCLES samples.
module ddrdll_code_sync
  import ddrdll_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic  clk_i,
  input  logic  rst_n_i,
  input  logic  dll_lock_i,
  input  code_t dll_code_i,
  output logic  lock_s_o,
  output code_t code_s_o,
  output logic  stable_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [1:0]       lock_q;
  code_t            code_meta_q;
  code_t            code_s_q;
  code_t            code_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (code_s_q != code_prev_q) cnt_d = '0;
    else if (cnt_q != CNT_MAX)   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lock_q      <= '0;
      code_meta_q <= '0;
      code_s_q    <= '0;
      code_prev_q <= '0;
      cnt_q       <= '0;
    end else begin
      lock_q      <= {lock_q[0], dll_lock_i};
      code_meta_q <= dll_code_i;
      code_s_q    <= code_meta_q;
      code_prev_q <= code_s_q;
      cnt_q       <= cnt_d;
    end
  end

  // A saturated counter alone would still be set during the first cycle of a new code.
  assign stable_o = (cnt_q == CNT_MAX) && (code_s_q == code_prev_q);
  assign lock_s_o = lock_q[1];
  assign code_s_o = code_s_q;

endmodule

// File: rtl/ddrdll_code_rx.sv
// Receive side of the DDRDLL delay-code link: filters the DLL code, applies the
// trim offset and pushes it to the DQS delay line over a req/ack handshake.
//
// state     | meaning
// WAIT_LOCK | no usable lock; next stable code is forced through
// TRACK     | locked; update only on enabled drift >= DRIFT_MIN
// FREEZE    | DLL frozen, target captured into upd_code
// REQ       | upd_req high, waiting for ack or timeout
// DONE      | ack seen; commit applied code and count
// RELEASE   | wait for ack low (skipped after timeout), unfreeze
module ddrdll_code_rx
  import ddrdll_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int DRIFT_MIN     = 2,
  parameter int ACK_TIMEOUT   = 64
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                dll_lock_i,
  input  code_t               dll_code_i,
  input  logic [OFFSET_W-1:0] code_offset_i,
  input  logic                upd_en_i,
  input  logic                upd_ack_i,
  output logic                dll_freeze_o,
  output logic                upd_req_o,
  output code_t               upd_code_o,
  output logic                code_valid_o,
  output logic                ack_err_o,
  output logic [7:0]          upd_count_o
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [CODE_W:0]  DRIFT_C  = (CODE_W+1)'(DRIFT_MIN);

  logic [1:0]       rst_sync_q;
  logic             rst_n_int;
  logic             lock_s;
  logic             stable;
  code_t            code_s;
  code_t            target;
  logic [CODE_W:0]  diff;
  logic [CODE_W:0]  drift;
  logic             drift_hit;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit_q, tmo_hit_d;
  code_t            upd_code_q, upd_code_d;
  code_t            applied_q, applied_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [7:0]       count_q, count_d;
  logic             freeze_q;
  logic             req_q;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  ddrdll_code_sync #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_sync (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_int),
    .dll_lock_i(dll_lock_i),
    .dll_code_i(dll_code_i),
    .lock_s_o  (lock_s),
    .code_s_o  (code_s),
    .stable_o  (stable)
  );

  assign target    = sat_add(code_s, code_offset_i);
  assign diff      = {1'b0, target} - {1'b0, applied_q};
  assign drift     = diff[CODE_W] ? (~diff + {{CODE_W{1'b0}}, 1'b1}) : diff;
  assign drift_hit = (drift >= DRIFT_C);

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    tmo_hit_d  = tmo_hit_q;
    upd_code_d = upd_code_q;
    applied_d  = applied_q;
    valid_d    = valid_q;
    err_d      = err_q;
    count_d    = count_q;
    case (state_q)
      S_WAIT_LOCK: begin
        if (lock_s && stable && !upd_ack_i) state_d = S_FREEZE;
      end
      S_TRACK: begin
        if (!lock_s) state_d = S_WAIT_LOCK;
        else if (upd_en_i && stable && drift_hit && !upd_ack_i) state_d = S_FREEZE;
      end
      S_FREEZE: begin
        upd_code_d = target;
        tmo_d      = TMO_LOAD;
        tmo_hit_d  = 1'b0;
        state_d    = S_REQ;
      end
      S_REQ: begin
        // Ack takes priority so an ack on the final timeout cycle still succeeds.
        if (upd_ack_i) begin
          state_d = S_DONE;
        end else if (tmo_q == '0) begin
          err_d     = 1'b1;
          tmo_hit_d = 1'b1;
          state_d   = S_RELEASE;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      S_DONE: begin
        applied_d = upd_code_q;
        valid_d   = 1'b1;
        count_d   = count_q + 8'd1;
        state_d   = S_RELEASE;
      end
      S_RELEASE: begin
        if (tmo_hit_q || !upd_ack_i) state_d = lock_s ? S_TRACK : S_WAIT_LOCK;
      end
      default: state_d = S_WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= S_WAIT_LOCK;
      tmo_q      <= '0;
      tmo_hit_q  <= 1'b0;
      upd_code_q <= '0;
      applied_q  <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= '0;
      freeze_q   <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      tmo_hit_q  <= tmo_hit_d;
      upd_code_q <= upd_code_d;
      applied_q  <= applied_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      count_q    <= count_d;
      freeze_q   <= (state_d != S_WAIT_LOCK) && (state_d != S_TRACK);
      req_q      <= (state_d == S_REQ);
    end
  end

  assign dll_freeze_o = freeze_q;
  assign upd_req_o    = req_q;
  assign upd_code_o   = upd_code_q;
  assign code_valid_o = valid_q;
  assign ack_err_o    = err_q;
  assign upd_count_o  = count_q;

endmodule

// File: tb/tb_ddrdll_code_rx.sv
// Directed-plus-random bench for ddrdll_code_rx against a clamp/threshold reference model.
module tb_ddrdll_code_rx;
  import ddrdll_pkg::*;

  localparam int STABLE_CYCLES = 4;
  localparam int DRIFT_MIN     = 2;
  localparam int ACK_TIMEOUT   = 64;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                dll_lock;
  code_t               dll_code;
  logic [OFFSET_W-1:0] code_offset;
  logic                upd_en;
  logic                upd_ack;
  logic                dll_freeze;
  logic                upd_req;
  code_t               upd_code;
  logic                code_valid;
  logic                ack_err;
  logic [7:0]          upd_count;

  int checks = 0;
  int errors = 0;
  int m_code = 0, m_off = 0, m_applied = 0, m_count = 0, m_total = 0;
  bit seen, dropped, bad;
  int cnt, lat;

  ddrdll_code_rx #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .DRIFT_MIN    (DRIFT_MIN),
    .ACK_TIMEOUT  (ACK_TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .dll_lock_i   (dll_lock),
    .dll_code_i   (dll_code),
    .code_offset_i(code_offset),
    .upd_en_i     (upd_en),
    .upd_ack_i    (upd_ack),
    .dll_freeze_o (dll_freeze),
    .upd_req_o    (upd_req),
    .upd_code_o   (upd_code),
    .code_valid_o (code_valid),
    .ack_err_o    (ack_err),
    .upd_count_o  (upd_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    dll_code    = CODE_W'(m_code);
    code_offset = OFFSET_W'(m_off);
  endtask

  function automatic int model_target(input int code, input int off);
    int t;
    t = code + off;
    if (t < 0)   t = 0;
    if (t > 511) t = 511;
    return t;
  endfunction

  task automatic expect_no_req(input string tag, input int n);
    bit saw;
    saw = 1'b0;
    repeat (n) begin
      tick();
      if (upd_req) saw = 1'b1;
    end
    check({tag, "_noreq"}, saw, 0);
  endtask

  task automatic do_update(input string tag, input int exp_code, input int ack_dly);
    bit got, fell, fr_ok;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (upd_req) begin got = 1'b1; break; end
    end
    check({tag, "_req"}, got, 1);
    if (!got) return;
    check({tag, "_code"}, upd_code, exp_code);
    fr_ok = dll_freeze;
    repeat (ack_dly) begin
      tick();
      fr_ok &= dll_freeze & upd_req;
    end
    upd_ack = 1'b1;
    fell = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (!upd_req) begin fell = 1'b1; break; end
    end
    check({tag, "_reqdrop"}, fell, 1);
    upd_ack = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (!dll_freeze) break;
    end
    check({tag, "_frzheld"}, fr_ok, 1);
    check({tag, "_frzrel"}, dll_freeze, 0);
    m_applied = exp_code;
    m_count   = (m_count + 1) % 256;
    m_total++;
    check({tag, "_count"}, upd_count, m_count);
    check({tag, "_valid"}, code_valid, 1);
  endtask

  task automatic eval_step(input string tag, input bit forced);
    int t, d;
    t = model_target(m_code, m_off);
    d = t - m_applied;
    if (d < 0) d = -d;
    if (forced || (upd_en && d >= DRIFT_MIN)) do_update(tag, t, int'($urandom_range(0, 3)));
    else expect_no_req(tag, STABLE_CYCLES + 12);
  endtask

  task automatic apply_code(input string tag, input int code);
    m_code = code;
    drive();
    eval_step(tag, 1'b0);
  endtask

  task automatic retarget(input string tag, input int code, input int off);
    upd_en = 1'b0;
    m_code = code;
    m_off  = off;
    drive();
    repeat (12) tick();
    upd_en = 1'b1;
    eval_step(tag, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1; dll_lock = 1'b0; upd_en = 1'b0; upd_ack = 1'b0;
    m_code = 'h080; m_off = 3; drive();
    #1 rst_n = 1'b0;
    #2;
    check("rst_req", upd_req, 0);
    check("rst_frz", dll_freeze, 0);
    check("rst_code", upd_code, 0);
    check("rst_valid", code_valid, 0);
    check("rst_err", ack_err, 0);
    check("rst_count", upd_count, 0);
    repeat (3) tick();
    rst_n = 1'b1;

    // first lock is forced even with tracking disabled
    expect_no_req("prelock", 16);
    dll_lock = 1'b1;
    do_update("first", 'h083, 2);

    upd_en = 1'b1;
    apply_code("drift_p1", 'h081);
    apply_code("drift_0", 'h080);
    apply_code("drift_p5", 'h085);
    apply_code("drift_p2", 'h087);
    apply_code("drift_m1", 'h086);
    upd_en = 1'b0;
    apply_code("en_off", 'h0F0);
    upd_en = 1'b1;
    eval_step("en_on", 1'b0);

    retarget("sat_hi", 'h1FE, 5);
    retarget("sat_lo", 'h002, -8);

    // code toggling faster than the stability window must never launch a transfer
    retarget("inst_pre", 'h100, 3);
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      m_code = (k % 2) ? 'h160 : 'h140;
      drive();
      repeat (2) begin
        tick();
        if (upd_req || dll_freeze) bad = 1'b1;
      end
    end
    check("inst_noreq", bad, 0);
    m_code = 'h150; drive();
    lat = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      lat++;
      if (upd_req) break;
    end
    check("inst_lat", (lat >= STABLE_CYCLES + 2) && (lat <= STABLE_CYCLES + 8), 1);
    do_update("inst_upd", 'h153, 1);

    // ack arriving on the last timeout cycle is a success
    upd_en = 1'b0; m_code = 'h020; m_off = 3; drive();
    repeat (12) tick();
    upd_en = 1'b1;
    do_update("tmo_edge", 'h023, ACK_TIMEOUT - 1);
    check("tmo_edge_err", ack_err, 0);

    upd_en = 1'b0; m_code = 'h050; drive();
    repeat (12) tick();
    upd_en = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (upd_req) begin seen = 1'b1; break; end
    end
    check("tmo_req", seen, 1);
    upd_en = 1'b0;
    cnt = 1;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (!upd_req) break;
      cnt++;
    end
    check("tmo_len", cnt, ACK_TIMEOUT);
    check("tmo_err", ack_err, 1);
    check("tmo_count", upd_count, m_count);
    repeat (3) tick();
    check("tmo_frz", dll_freeze, 0);
    upd_en = 1'b1;
    eval_step("tmo_retry", 1'b0);

    // lock lost while the request is outstanding
    upd_en = 1'b0; m_code = 'h0A0; drive();
    repeat (12) tick();
    upd_en = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (upd_req) begin seen = 1'b1; break; end
    end
    check("ll_req", seen, 1);
    dll_lock = 1'b0;
    repeat (4) tick();
    upd_ack = 1'b1;
    dropped = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (!upd_req) begin dropped = 1'b1; break; end
    end
    check("ll_drop", dropped, 1);
    upd_ack = 1'b0;
    repeat (4) tick();
    m_applied = model_target(m_code, m_off);
    m_count   = (m_count + 1) % 256;
    m_total++;
    check("ll_count", upd_count, m_count);
    check("ll_frz", dll_freeze, 0);
    expect_no_req("ll_nolock", 16);
    check("ll_valid", code_valid, 1);
    dll_lock = 1'b1;
    eval_step("relock", 1'b1);

    // random tracking; runs long enough for upd_count to wrap
    upd_en = 1'b0;
    m_off = int'($urandom_range(0, 16)) - 8;
    drive();
    repeat (12) tick();
    upd_en = 1'b1;
    eval_step("rnd_init", 1'b0);
    for (int s = 0; s < 600 && m_total < 300; s++) begin
      if ($urandom_range(0, 1) == 1) begin
        m_code = int'($urandom_range(0, 511));
      end else begin
        m_code = m_code + int'($urandom_range(0, 6)) - 3;
        if (m_code < 0)   m_code = 0;
        if (m_code > 511) m_code = 511;
      end
      drive();
      eval_step("rnd", 1'b0);
    end

    // reset in the middle of a transfer
    upd_en = 1'b0; m_off = 0; m_code = (m_applied + 256) % 512; drive();
    repeat (12) tick();
    upd_en = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (upd_req) begin seen = 1'b1; break; end
    end
    check("mr_req", seen, 1);
    rst_n = 1'b0;
    #1;
    check("mr_req0", upd_req, 0);
    check("mr_frz0", dll_freeze, 0);
    check("mr_code0", upd_code, 0);
    check("mr_valid0", code_valid, 0);
    check("mr_err0", ack_err, 0);
    check("mr_count0", upd_count, 0);
    m_count = 0;
    m_applied = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    eval_step("post_rst", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
